// File: rtl/ascon_pkg.sv
// ascon_pkg: shared Ascon state type and the forward/inverse 5-bit S-box tables.
// Column packing: {word0, word1, word2, word3, word4} with word 0 as the MSB.
package ascon_pkg;
  localparam int NUM_WORDS = 5;
  localparam int WORD_WIDTH = 64;
  typedef logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] ascon_state_t;
  localparam logic [0:31][4:0] SBOX = {
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
  localparam logic [0:31][4:0] INV_SBOX = {
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
  };
endpackage

// File: rtl/inv_sbox_column.sv
// inv_sbox_column: combinational inverse Ascon S-box on one bit-sliced column.
module inv_sbox_column
  import ascon_pkg::*;
(
  input  logic [4:0] col,
  output logic [4:0] inv
);
  assign inv = INV_SBOX[col];
endmodule

// File: rtl/inv_substitution_engine.sv
// inv_substitution_engine: iterative inverse Ascon S-box layer, COLS_PER_CYCLE columns per clock.
// Optional forward-table self-check enabled by ASCON_INV_SBOX_SELFCHECK_EN.
module inv_substitution_engine
  import ascon_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  ascon_state_t state_array_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output ascon_state_t state_array_o,
  output logic         check_err_o
);
  localparam int C = COLS_PER_CYCLE;
  localparam int N = 64 / C;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  if (!(C == 1 || C == 2 || C == 4 || C == 8 || C == 16 || C == 32 || C == 64)) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2, 4, 8, 16, 32 or 64");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e st, st_nx;
  logic [CW-1:0] cnt;
  logic last;
  logic [5:0] base;
  ascon_state_t work, upd;
  logic [C-1:0][4:0] cin, cout;
  assign last = cnt == CW'(N - 1);
  assign base = 6'(cnt * C);
  for (genvar i = 0; i < C; i++) begin : g_col
    assign cin[i] = {work[0][base + 6'(i)], work[1][base + 6'(i)], work[2][base + 6'(i)],
                     work[3][base + 6'(i)], work[4][base + 6'(i)]};
    inv_sbox_column u_col (.col(cin[i]), .inv(cout[i]));
  end
  always_comb begin
    upd = work;
    for (int i = 0; i < C; i++)
      for (int k = 0; k < NUM_WORDS; k++)
        upd[k][base + 6'(i)] = cout[i][3'(4 - k)];
  end
  always_comb begin
    st_nx = st;
    st_nx = (st == IDLE && in_valid_i) ? RUN :
            (st == RUN && last)        ? DONE :
            (st == DONE && out_ready_i) ? IDLE : st;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st   <= IDLE;
      cnt  <= '0;
      work <= '0;
    end else begin
      st <= st_nx;
      if (st == IDLE && in_valid_i) begin
        work <= state_array_i;
        cnt  <= '0;
      end else if (st == RUN) begin
        work <= upd;
        cnt  <= last ? '0 : cnt + 1'b1;
      end
    end
  end
  assign in_ready_o    = st == IDLE;
  assign out_valid_o   = st == DONE;
  assign state_array_o = work;
`ifdef ASCON_INV_SBOX_SELFCHECK_EN
  // Re-applying the forward box to each fresh result must reproduce its source column.
  logic err, mis;
  always_comb begin
    mis = 1'b0;
    for (int i = 0; i < C; i++) mis = mis | (SBOX[cout[i]] != cin[i]);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err <= 1'b0;
    else if (st == IDLE && in_valid_i) err <= 1'b0;
    else if (st == RUN) err <= err | mis;
  end
  assign check_err_o = err & out_valid_o;
`else
  assign check_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_inv_substitution_engine.sv
// tb_inv_substitution_engine: scoreboard bench over four engines (C = 8, 1, 4, 64).
module tb_inv_substitution_engine;
  import ascon_pkg::*;
  localparam logic [0:31][4:0] FW = {
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
  typedef struct {
    ascon_state_t si;
    ascon_state_t se;
    bit           he;
  } txn_t;
  logic clk = 1'b0, rst = 1'b1, rnd_en = 1'b0;
  logic in_valid[4], in_ready[4], out_valid[4], out_ready[4], check_err[4], ov_d[4];
  ascon_state_t din[4], dout[4];
  txn_t q[4][$];
  int checks = 0, fails = 0, cyc = 0;
  int acc_cyc[4];
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (rnd_en) begin #1; out_ready[0] = 1'($urandom_range(0, 1)); end
  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic ascon_state_t mk(input logic [4:0] m);
    ascon_state_t r;
    for (int k = 0; k < 5; k++) r[k] = {64{m[4-k]}};
    return r;
  endfunction
  function automatic ascon_state_t fwd(input ascon_state_t s);
    ascon_state_t r;
    logic [4:0] x;
    for (int j = 0; j < 64; j++) begin
      x = FW[{s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]}];
      for (int k = 0; k < 5; k++) r[k][j] = x[4-k];
    end
    return r;
  endfunction
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int CC = g == 0 ? 8 : g == 1 ? 1 : g == 2 ? 4 : 64;
    txn_t t;
    inv_substitution_engine #(.COLS_PER_CYCLE(CC)) u_dut (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid[g]), .in_ready_o(in_ready[g]),
      .state_array_i(din[g]), .out_valid_o(out_valid[g]), .out_ready_i(out_ready[g]),
      .state_array_o(dout[g]), .check_err_o(check_err[g]));
    always @(negedge clk) begin
      if (!rst && in_valid[g] && in_ready[g]) acc_cyc[g] = cyc + 1;
      if (out_valid[g] && !ov_d[g]) chk($sformatf("latency[C=%0d]", CC), cyc - acc_cyc[g], 64 / CC);
      ov_d[g] = out_valid[g];
      if (out_valid[g] && out_ready[g]) begin
        if (q[g].size() == 0) chk($sformatf("unexpected_output[C=%0d]", CC), 1, 0);
        else begin
          t = q[g].pop_front();
          if (t.he) chk($sformatf("data[C=%0d]", CC), dout[g], t.se);
          chk($sformatf("roundtrip[C=%0d]", CC), fwd(dout[g]), t.si);
          chk($sformatf("check_err[C=%0d]", CC), check_err[g], 0);
        end
      end
    end
  end
  task automatic send(input int g, input ascon_state_t s, input ascon_state_t e, input bit he);
    int t = 0;
    txn_t x;
    din[g] = s;
    in_valid[g] = 1'b1;
    while (!in_ready[g] && t < 500) begin @(posedge clk); #1; t++; end
    if (t >= 500) chk("accept_timeout", 1, 0);
    x.si = s; x.se = e; x.he = he;
    q[g].push_back(x);
    @(posedge clk); #1;
    in_valid[g] = 1'b0;
  endtask
  task automatic drain(input int g);
    int t = 0;
    while (q[g].size() != 0 && t < 3000) begin @(posedge clk); #1; t++; end
    if (t >= 3000) chk("drain_timeout", q[g].size(), 0);
  endtask
  initial begin
    ascon_state_t s;
    txn_t x;
    int t;
    for (int g = 0; g < 4; g++) begin
      in_valid[g] = 1'b0; out_ready[g] = 1'b1; din[g] = '0; ov_d[g] = 1'b0; acc_cyc[g] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < 4; g++) begin
      chk("reset_in_ready", in_ready[g], 1);
      chk("reset_out_valid", out_valid[g], 0);
      chk("reset_state", dout[g], 0);
      chk("reset_check_err", check_err[g], 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    send(0, mk(5'b00000), mk(5'b10100), 1);
    send(0, mk(5'b11111), mk(5'b00010), 1);
    send(0, mk(5'b10000), mk(5'b11000), 1);
    for (int g = 1; g < 4; g++) begin
      send(g, mk(5'b11111), mk(5'b00010), 1);
      send(g, mk(5'b00000), mk(5'b10100), 1);
    end
    for (int g = 0; g < 4; g++) drain(g);
    // Stall the consumer in DONE while a competing input is offered.
    out_ready[0] = 1'b0;
    send(0, mk(5'b00000), mk(5'b10100), 1);
    t = 0;
    while (!out_valid[0] && t < 100) begin @(posedge clk); #1; t++; end
    din[0] = mk(5'b10000);
    in_valid[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      chk("hold_out_valid", out_valid[0], 1);
      chk("hold_data", dout[0], mk(5'b10100));
      chk("hold_in_ready", in_ready[0], 0);
      @(posedge clk); #1;
    end
    x.si = mk(5'b10000); x.se = mk(5'b11000); x.he = 1;
    q[0].push_back(x);
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("post_handshake_idle", in_ready[0], 1);
    @(posedge clk); #1;
    chk("next_accept", in_ready[0], 0);
    in_valid[0] = 1'b0;
    drain(0);
    // Reset while the engine sits at cnt=3.
    send(0, mk(5'b11111), mk(5'b00010), 1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrun_rst_in_ready", in_ready[0], 1);
    chk("midrun_rst_out_valid", out_valid[0], 0);
    chk("midrun_rst_state", dout[0], 0);
    chk("midrun_rst_check_err", check_err[0], 0);
    q[0].delete();
    @(posedge clk); #1;
    rst = 1'b0;
    send(0, mk(5'b00000), mk(5'b10100), 1);
    drain(0);
    rnd_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      for (int k = 0; k < 5; k++) s[k] = {$urandom(), $urandom()};
      send(0, s, '0, 0);
    end
    drain(0);
    rnd_en = 1'b0;
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    for (int g = 0; g < 4; g++) drain(g);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/inv_substitution_engine.md
# inv_substitution_engine

Iterative inverse of the Ascon S-box layer (NIST SP 800-232 Table 6, inverted). It accepts a full 320-bit state over a valid/ready handshake and replaces COLS_PER_CYCLE bit-sliced columns per clock until all 64 columns are inverted. It then presents the result over a second valid/ready handshake. It is used for inverse-permutation experiments and for round-trip checking of the forward permutation datapath.

## Interface
- COLS_PER_CYCLE, default 8: columns inverted per cycle. Legal values are 1, 2, 4, 8, 16, 32 or 64. Any other value is an elaboration `$error`.
- clk_i, input, 1: single clock.
- rst_i, input, 1: reset, asynchronous, active-high.
- in_valid_i, input, 1: input state offered.
- in_ready_o, output, 1: engine can accept a state.
- state_array_i, input, ascon_state_t (5×64): state to invert.
- out_valid_o, output, 1: result available.
- out_ready_i, input, 1: consumer takes the result.
- state_array_o, output, ascon_state_t: inverted state.
- check_err_o, output, 1: self-check mismatch flag (see Configuration).

## Operation
- Column j index = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]}, with word 0 as the MSB. The output column uses the same packing.
- INV_SBOX table, indexed 0x00–0x1f: 14 1a 07 0d 00 09 0e 12 0a 06 1d 01 19 15 13 1e 18 16 0b 11 03 05 1c 1f 17 1b 04 08 0f 0c 10 02.
- FSM states and transitions:
  - IDLE: in_ready_o=1. On in_valid_i&in_ready_o, capture state_array_i into the working register, set cnt=0, go to RUN.
  - RUN: each cycle, replace columns [cnt*C +: C] of the working register with INV_SBOX of themselves, then increment cnt. On the edge that processes chunk N−1 (N=64/C), go to DONE.
  - DONE: out_valid_o=1 and the working register is stable. On out_ready_i, go to IDLE.
- cnt has width max(1,$clog2(N)) and wraps to 0 on leaving RUN.
- in_valid_i is ignored outside IDLE. No input is dropped: in_ready_o=0 outside IDLE.
- state_array_o always drives the working register. It is meaningful only while out_valid_o=1.
- Reset values: in_ready_o=1 (IDLE), out_valid_o=0, state_array_o=0, check_err_o=0, cnt=0.
- Reset mid-operation (RUN or DONE): go immediately to IDLE. The in-flight state is discarded and the working register is cleared.

## Timing
- Accept on edge k. Chunks are processed on edges k+1 … k+N. out_valid_o is high from edge k+N.
- Latency is N cycles (8 for the default). At C=64 the latency is 1.
- Output handshake on edge k+N+m (m≥1, waiting for out_ready_i) → IDLE. The earliest next accept is one edge later.
- Minimum accept-to-accept period is N+2 cycles.
- out_valid_o and state_array_o hold stable while out_ready_i=0 for any number of cycles.
- The output handshake and a new input offer in the same cycle do not overlap: the input is accepted only in the following IDLE cycle.

## Configuration
- Macro: ASCON_INV_SBOX_SELFCHECK_EN.
- Defined:
  - Each RUN cycle, apply the forward S-box to the newly inverted chunk and compare it with the pre-update chunk.
  - Any mismatch sets a sticky error bit.
  - check_err_o = sticky bit, qualified by out_valid_o.
  - The sticky bit is cleared on accept and on reset.
- Undefined: no forward table and no comparators. check_err_o is tied to 0. The port is always present so the interface is stable.

## Structure
- ascon_pkg gains:
  - INV_SBOX localparam (32×5 bits), next to the forward table.
  - The forward table itself, moved into the package if it is not already there.
- ascon_pkg reuses ascon_state_t, NUM_WORDS=5 and WORD_WIDTH=64.
- FSM state enum is local to the module.
- One sub-module, inv_sbox_column: a combinational 5-bit in / 5-bit out lookup, instantiated COLS_PER_CYCLE times in a generate loop on the chunk slice.

## Test plan
- All-zero state, C=8 → after 8 cycles, words 0 and 2 = 0xFFFF_FFFF_FFFF_FFFF, words 1, 3 and 4 = 0.
- All-ones state → word 3 = 0xFFFF_FFFF_FFFF_FFFF, others 0. Repeat for C=1, 4 and 64; latency must be 64, 16 and 1 respectively.
- Word 0 all ones, others 0 → words 0 and 1 all ones, others 0.
- Hold out_ready_i=0 for 20 cycles in DONE:
  - out_valid_o and data stay stable.
  - in_ready_o=0 throughout.
  - in_valid_i pulses are not consumed.
  - After the handshake, the next accept occurs exactly one cycle later.
- Assert rst_i at cnt=3 in RUN:
  - Outputs immediately take reset values.
  - A subsequent all-zero input yields the first vector.
- 1000 random states with out_ready_i randomised:
  - The forward S-box model applied to the output equals the input.
  - With ASCON_INV_SBOX_SELFCHECK_EN defined, check_err_o=0 throughout.
